// File: rtl/mult_sequencer.sv
// Control sequencer for a shift-and-add signed multiplier (A:B accumulator, X sign bit).
// Add/Sub strobes combine the state decode with the multiplier LSB M; every other output is a pure state decode.
module mult_sequencer #(
    parameter int N_BITS = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic       M,
    output logic       Clr_Ld,
    output logic       ClrA_X,
    output logic       Add,
    output logic       Sub,
    output logic       Shift,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] Count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_ADD,
        S_SHIFT,
        S_HOLD
    } state_t;

    localparam logic [3:0] LAST_ITER  = 4'(N_BITS - 1);
    localparam logic [3:0] ITER_TOTAL = 4'(N_BITS);

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: every output is given a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        Clr_Ld  = 1'b0;
        ClrA_X  = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Shift   = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ClearA_LoadB) begin
                    state_d = S_LOAD;
                end else if (Run) begin
                    state_d = S_START;
                end
            end
            S_LOAD: begin
                Clr_Ld  = 1'b1;
                state_d = S_IDLE;
            end
            S_START: begin
                ClrA_X  = 1'b1;
                Busy    = 1'b1;
                count_d = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                // The final partial product carries the multiplier sign bit, so it is subtracted.
                Busy    = 1'b1;
                Add     = M && (count_q != LAST_ITER);
                Sub     = M && (count_q == LAST_ITER);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                Busy    = 1'b1;
                Shift   = 1'b1;
                count_d = count_q + 4'd1;
                state_d = (count_d == ITER_TOTAL) ? S_HOLD : S_ADD;
            end
            S_HOLD: begin
                Done = 1'b1;
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Count = count_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: drives a behavioural X:A:B datapath from the strobes
// and compares per-cycle outputs and final products against a scoreboard of expected products.
module tb_mult_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       cl_lb;
    logic       m;
    logic       clr_ld, clra_x, add, sub, shift, busy, done;
    logic [3:0] count;

    logic [6:0] outs;
    logic [7:0] sw_s, sw_b;
    logic [7:0] x_r = '0, a_r = '0, b_r = '0;
    logic [7:0] b_cur;
    logic [15:0] last_prod;

    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_fails  = 0;

    mult_sequencer #(.N_BITS(8)) dut (
        .Clk          (clk),
        .Reset        (rst),
        .Run          (run),
        .ClearA_LoadB (cl_lb),
        .M            (m),
        .Clr_Ld       (clr_ld),
        .ClrA_X       (clra_x),
        .Add          (add),
        .Sub          (sub),
        .Shift        (shift),
        .Busy         (busy),
        .Done         (done),
        .Count        (count)
    );

    always #5 clk = ~clk;

    assign outs = {clr_ld, clra_x, add, sub, shift, busy, done};
    assign m    = b_r[0];

    // Datapath the sequencer controls; A+S / A-S are 9-bit sign-extended with X taking bit 8.
    always @(posedge clk) begin
        if (clr_ld) begin
            x_r <= '0;
            a_r <= '0;
            b_r <= sw_b;
        end else if (clra_x) begin
            x_r <= '0;
            a_r <= '0;
        end else if (add) begin
            {x_r[0], a_r} <= {a_r[7], a_r} + {sw_s[7], sw_s};
            x_r[7:1]      <= '0;
        end else if (sub) begin
            {x_r[0], a_r} <= {a_r[7], a_r} - {sw_s[7], sw_s};
            x_r[7:1]      <= '0;
        end else if (shift) begin
            a_r <= {x_r[0], a_r[7:1]};
            b_r <= {a_r[0], b_r[7:1]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [6:0] exp);
        check(tag, {9'b0, outs}, {9'b0, exp});
    endtask

    task automatic check_cnt(input string tag, input int exp);
        check(tag, {12'b0, count}, 16'(exp));
    endtask

    task automatic push_prod(input logic [7:0] s, input logic [7:0] b);
        int p;
        p = int'($signed(s)) * int'($signed(b));
        exp_q.push_back(p[15:0]);
    endtask

    // Entered one cycle after Run was seen in IDLE (START cycle already current).
    task automatic check_mult(input logic [7:0] b, input int hold);
        logic [15:0] exp_p;
        check_outs("start", 7'b0100010);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_outs($sformatf("add%0d", i),
                       {2'b00, (i < 7) & b[i], (i == 7) & b[i], 3'b010});
            check_cnt($sformatf("add_cnt%0d", i), i);
            tick();
            check_outs($sformatf("shift%0d", i), 7'b0000110);
            check_cnt($sformatf("shift_cnt%0d", i), i);
        end
        tick();
        check_outs("hold", 7'b0000001);
        check_cnt("hold_cnt", 8);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 16'd1, 16'd0);
            exp_p = 'x;
        end else begin
            exp_p = exp_q.pop_front();
            check("product", {a_r, b_r}, exp_p);
        end
        last_prod = exp_p;
        for (int k = 1; k < hold; k++) begin
            tick();
            check_outs($sformatf("hold_stay%0d", k), 7'b0000001);
        end
    endtask

    initial begin
        rst   = 1'b1;
        run   = 1'b0;
        cl_lb = 1'b0;
        sw_s  = 8'h07;
        sw_b  = 8'h03;
        #1;
        check_outs("reset_outs", 7'b0);
        check_cnt("reset_cnt", 0);
        #20;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_outs("idle_after_reset", 7'b0);

        // Load B = 0x03
        cl_lb = 1'b1;
        tick();
        check_outs("load", 7'b1000000);
        cl_lb = 1'b0;
        tick();
        check_outs("load_idle", 7'b0);
        b_cur = sw_b;

        // 0x07 x 0x03 with Run held through 50 Done cycles
        run = 1'b1;
        push_prod(sw_s, b_cur);
        tick();
        check_mult(b_cur, 50);
        run = 1'b0;
        tick();
        check_outs("release_idle", 7'b0);
        b_cur = last_prod[7:0];

        // Back-to-back multiply reusing the shifted B (low product byte)
        sw_s = 8'h09;
        run  = 1'b1;
        push_prod(sw_s, b_cur);
        tick();
        check_mult(b_cur, 1);
        run = 1'b0;
        tick();
        check_outs("reuse_idle", 7'b0);

        // Simultaneous Run + ClearA_LoadB: LOAD, IDLE, then START; 0x05 x 0xFE
        sw_s  = 8'h05;
        sw_b  = 8'hFE;
        run   = 1'b1;
        cl_lb = 1'b1;
        push_prod(sw_s, sw_b);
        tick();
        check_outs("both_load", 7'b1000000);
        cl_lb = 1'b0;
        tick();
        check_outs("both_idle", 7'b0);
        tick();
        b_cur = sw_b;
        check_mult(b_cur, 3);
        run = 1'b0;
        tick();
        check_outs("neg_idle", 7'b0);

        // Reset in the SHIFT cycle with Count=4
        run = 1'b1;
        tick();
        check_outs("abort_start", 7'b0100010);
        repeat (10) tick();
        check_outs("abort_shift", 7'b0000110);
        check_cnt("abort_cnt_pre", 4);
        rst = 1'b1;
        run = 1'b0;
        #1;
        check_outs("abort_outs", 7'b0);
        check_cnt("abort_cnt", 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_outs("abort_idle", 7'b0);

        // Full multiply after the abort: 0x83 x 0x81
        sw_s  = 8'h83;
        sw_b  = 8'h81;
        cl_lb = 1'b1;
        tick();
        check_outs("load2", 7'b1000000);
        cl_lb = 1'b0;
        tick();
        b_cur = sw_b;
        run   = 1'b1;
        push_prod(sw_s, b_cur);
        tick();
        check_mult(b_cur, 2);
        run = 1'b0;
        tick();
        check_outs("final_idle", 7'b0);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
